// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter on the CPU's external bus.
//
// Register map (word addresses):
//   BASE_ADDR     TXDATA  write: push wdata[7:0] into the TX FIFO
//                         read : 16'h0000
//   BASE_ADDR+1   STATUS  read : {12'b0, overflow, busy, full, empty}
//                         write: any value clears overflow
//
// Ports:
//   clk      in   system clock, rising-edge
//   rst_n    in   asynchronous active-low reset
//   address  in   [15:0] CPU address bus
//   wdata    in   [15:0] CPU write data (data_out)
//   wren_n   in   CPU write strobe, active low, one cycle per write
//   oen_n    in   CPU read strobe, active low
//   rdata    out  [15:0] read data, combinational, zero when not selected
//   sel      out  high when address hits TXDATA or STATUS, combinational
//   tx       out  serial line, idles high, LSB first, one stop bit
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        wren_n,
    input  logic        oen_n,
    output logic [15:0] rdata,
    output logic        sel,
    output logic        tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [15:0]      BAUD_LAST = CLK_DIV - 16'd1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Elaboration-time parameter sanity checks.
    if (CLK_DIV < 16'd2) begin : g_bad_div
        $error("mmio_uart_tx: CLK_DIV must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mmio_uart_tx: FIFO_DEPTH must be a power of two, minimum 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic hit_data;
    logic hit_stat;
    logic push_req;
    logic clr_ovf;

    assign hit_data = (address == BASE_ADDR);
    assign hit_stat = (address == (BASE_ADDR + 16'd1));
    assign sel      = hit_data | hit_stat;
    assign push_req = ~wren_n & hit_data;
    assign clr_ovf  = ~wren_n & hit_stat;

    // The upper write byte is architecturally ignored.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[15:8];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;

    state_e           state_q, state_d;
    logic [15:0]      baud_q,  baud_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q,    tx_d;

    logic fifo_empty;
    logic fifo_full;
    logic push_ok;
    logic pop;
    logic baud_end;
    logic busy;

    // Full/empty come from the count before the edge, so a push into a full
    // FIFO is dropped even if the transmitter pops on the same edge.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign push_ok    = push_req & ~fifo_full;
    assign baud_end   = (baud_q == BAUD_LAST);
    assign busy       = (state_q != ST_IDLE);

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    // Combinational so the CPU can sample it on the same edge as oen_n.
    assign rdata = (~oen_n & hit_stat)
                 ? {12'b0, overflow_q, busy, fifo_full, fifo_empty}
                 : 16'h0000;

    assign tx = tx_q;

    // -------------------------------------------------------------------------
    // FIFO next-state
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A dropped push and a STATUS write hit different addresses, so they
        // can never coincide.
        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: the storage array carries no reset; count and pointers define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= wdata[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (baud_end) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        // The bit going out next is shift_q[1]; shifting keeps
                        // the current bit at shift_q[0].
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits,
                    // so back-to-back bytes have no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Self-checking bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// Inputs change on the falling clock edge; outputs are sampled on the falling
// edge (or 1 ns after an input change for combinational paths). A background
// receiver decodes every frame on tx into rx_q.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam int BIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        wren_n;
    logic        oen_n;
    logic [15:0] rdata;
    logic        sel;
    logic        tx;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR (16'hFF00),
        .CLK_DIV   (16'd4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .address(address),
        .wdata  (wdata),
        .wren_n (wren_n),
        .oen_n  (oen_n),
        .rdata  (rdata),
        .sel    (sel),
        .tx     (tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called on the falling edge of cycle 0 of a start bit; checks tx on every
    // cycle of the 10-bit frame and returns on cycle 0 after the stop bit.
    task automatic check_frame(input logic [7:0] b, input bit do_mid, input logic [15:0] exp_mid);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < BIT; c++) begin
                check($sformatf("frame_%02h_bit%0d", b, k), tx, bits[k]);
                if (do_mid && k == 5 && c == 0) begin
                    check("status_mid_frame", rdata, exp_mid);
                end
                step();
            end
        end
    endtask

    // Background receiver: samples mid-bit, drops any frame cut by reset.
    initial begin : monitor
        logic [7:0] rx_byte;
        logic       start_ok;
        logic       stop_ok;
        logic       aborted;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rx_byte  = '0;
                start_ok = 1'b0;
                stop_ok  = 1'b0;
                aborted  = 1'b0;
                for (int c = 1; c < 10 * BIT; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1'b1;
                    if (c % BIT == BIT / 2) begin
                        if (c / BIT == 0)      start_ok = (tx === 1'b0);
                        else if (c / BIT == 9) stop_ok  = (tx === 1'b1);
                        else                   rx_byte[c / BIT - 1] = tx;
                    end
                end
                if (!aborted) begin
                    check("rx_framing", {30'b0, start_ok, stop_ok}, 32'h3);
                    rx_q.push_back(rx_byte);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [15:0] address;
        logic        oen_n;
        logic        exp_sel;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    logic [7:0] ovf_bytes [6];

    initial begin : main
        int bad;

        vecs[0] = '{"rd_status",      16'hFF01, 1'b0, 1'b1, 16'h0001};
        vecs[1] = '{"rd_txdata",      16'hFF00, 1'b0, 1'b1, 16'h0000};
        vecs[2] = '{"rd_ff02",        16'hFF02, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{"rd_0000",        16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{"status_no_oen",  16'hFF01, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{"rd_feff",        16'hFEFF, 1'b0, 1'b0, 16'h0000};

        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        rst_n   = 1'b0;
        address = 16'h0000;
        wdata   = 16'h0000;
        wren_n  = 1'b1;
        oen_n   = 1'b1;

        // ---- Reset state and decode table, applied while reset is held ----
        repeat (3) step();
        check("reset_tx", tx, 1'b1);
        check("reset_rdata_idle", rdata, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            address = vecs[i].address;
            oen_n   = vecs[i].oen_n;
            #1;
            check({vecs[i].name, "_sel"},   sel,   vecs[i].exp_sel);
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
        end
        address = 16'h0000;
        oen_n   = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // ---- Single byte: latency, frame shape, STATUS mid and after ----
        rx_q.delete();
        address = 16'hFF00;
        wdata   = 16'h1255;
        wren_n  = 1'b0;
        step();
        wren_n  = 1'b1;
        address = 16'hFF01;
        oen_n   = 1'b0;
        #1;
        check("single_tx_before_fall", tx, 1'b1);
        check("single_status_queued", rdata, 16'h0000);
        step();
        check_frame(8'h55, 1'b1, 16'h0005);
        check("single_status_after", rdata, 16'h0001);
        check("single_tx_idle", tx, 1'b1);
        oen_n = 1'b1;
        repeat (2) step();
        check("single_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) check("single_rx_byte", rx_q[0], 8'h55);

        // ---- Back-to-back: no idle cycle between frames ----
        rx_q.delete();
        address = 16'hFF00;
        wdata   = 16'h00A0;
        wren_n  = 1'b0;
        step();
        wdata   = 16'h000F;
        step();
        wren_n  = 1'b1;
        check_frame(8'hA0, 1'b0, 16'h0000);
        check_frame(8'h0F, 1'b0, 16'h0000);
        check("b2b_tx_idle", tx, 1'b1);
        repeat (2) step();
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx_byte0", rx_q[0], 8'hA0);
            check("b2b_rx_byte1", rx_q[1], 8'h0F);
        end

        // ---- Overflow: one in flight, four queued, fifth dropped ----
        rx_q.delete();
        address = 16'hFF00;
        wren_n  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wdata = {8'hEE, ovf_bytes[i]};
            step();
        end
        wren_n  = 1'b1;
        address = 16'hFF01;
        oen_n   = 1'b0;
        #1;
        check("ovf_status_set", rdata, 16'h000E);
        step();
        oen_n  = 1'b1;
        wdata  = 16'h1234;
        wren_n = 1'b0;
        step();
        wren_n = 1'b1;
        oen_n  = 1'b0;
        #1;
        check("ovf_status_cleared", rdata, 16'h0006);
        oen_n = 1'b1;
        repeat (5 * 10 * BIT + 20) step();
        oen_n = 1'b0;
        #1;
        check("ovf_status_drained", rdata, 16'h0001);
        oen_n = 1'b1;
        check("ovf_rx_count", rx_q.size(), 5);
        if (rx_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("ovf_rx_byte%0d", i), rx_q[i], ovf_bytes[i]);
            end
        end

        // ---- Reset during DATA bit 3 ----
        rx_q.delete();
        address = 16'hFF00;
        wdata   = 16'h00F5;
        wren_n  = 1'b0;
        step();
        wren_n  = 1'b1;
        step();
        repeat (17) step();
        check("mid_reset_tx_before", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_tx_async", tx, 1'b1);
        repeat (2) step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) bad++;
        end
        check("post_reset_tx_quiet", bad, 0);
        address = 16'hFF01;
        oen_n   = 1'b0;
        #1;
        check("post_reset_status", rdata, 16'h0001);
        oen_n = 1'b1;
        check("post_reset_rx_count", rx_q.size(), 0);
        address = 16'hFF00;
        wdata   = 16'h005A;
        wren_n  = 1'b0;
        step();
        wren_n  = 1'b1;
        repeat (10 * BIT + 10) step();
        check("post_reset_new_count", rx_q.size(), 1);
        if (rx_q.size() == 1) check("post_reset_new_byte", rx_q[0], 8'h5A);

        // ---- Decode: writes elsewhere are ignored ----
        rx_q.delete();
        address = 16'hFF02;
        wdata   = 16'h00AA;
        wren_n  = 1'b0;
        step();
        wren_n  = 1'b1;
        address = 16'h0000;
        oen_n   = 1'b0;
        #1;
        check("decode_0000_sel", sel, 1'b0);
        check("decode_0000_rdata", rdata, 16'h0000);
        address = 16'hFF01;
        oen_n   = 1'b1;
        #1;
        check("decode_ff01_no_oen", rdata, 16'h0000);
        oen_n = 1'b0;
        #1;
        check("decode_status_unchanged", rdata, 16'h0001);
        oen_n = 1'b1;
        repeat (10 * BIT + 10) step();
        check("decode_tx_idle", tx, 1'b1);
        check("decode_rx_count", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
